// File: rtl/gcd_arbiter_pkg.sv
// Shared types for the GCD arbiter: id width helper, operand pair, tag.
// Optional feature macro used by the top: GCD_ARBITER_PERF_EN.
package gcd_arbiter_pkg;

  localparam int W_DEF    = 16;
  localparam int NREQ_DEF = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDW = id_width(NREQ_DEF);

  typedef logic [IDW-1:0] tag_t;

  typedef struct packed {
    logic [W_DEF-1:0] a;
    logic [W_DEF-1:0] b;
  } opnd_t;

endpackage

// File: rtl/gcd_arbiter_tagq.sv
// In-order owner-tag FIFO: DEPTH x IDW, push/pop, full/empty, head tag.
// Ports: clk, reset_n, push, pop, din -> head, full, empty.
module gcd_arbiter_tagq
  import gcd_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDW   = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           push,
  input  logic           pop,
  input  logic [IDW-1:0] din,
  output logic [IDW-1:0] head,
  output logic           full,
  output logic           empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IDW-1:0] mem [DEPTH];
  logic [AW-1:0]  rd;
  logic [AW-1:0]  wr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= nxt(wr);
      if (do_pop)  rd <= nxt(rd);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin share of one GCD unit among NREQ requesters; results routed
// back via an in-order tag queue. Optional GCD_ARBITER_PERF_EN adds perf_cnt.
// Ports: clk, reset_n, req_msg/val/rdy, resp_msg/val/rdy, gcd_in_*, gcd_out_*.
module gcd_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
`ifdef GCD_ARBITER_PERF_EN
  output logic [NREQ*16-1:0]    perf_cnt,
`endif
  input  logic [NREQ*2*W-1:0]   req_msg,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rdy,
  output logic [W-1:0]          resp_msg,
  output logic [NREQ-1:0]       resp_val,
  input  logic [NREQ-1:0]       resp_rdy,
  output logic [W-1:0]          gcd_in_A,
  output logic [W-1:0]          gcd_in_B,
  output logic                  gcd_in_val,
  input  logic                  gcd_in_rdy,
  input  logic [W-1:0]          gcd_out,
  input  logic                  gcd_out_val,
  output logic                  gcd_out_rdy
);

  localparam int IW = id_width(NREQ);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   hd;
  logic [NREQ-1:0] gnt;
  logic [2*W-1:0]  sel;
  logic            full;
  logic            empty;
  logic            can_issue;
  logic            fire;
  logic            ret_fire;

  // Walk from farthest to nearest so the slot closest to ptr wins.
  always_comb begin
    logic [IW-1:0] ix;
    gnt  = '0;
    gidx = '0;
    ix   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      ix = IW'((int'(ptr) + k) % NREQ);
      if (req_val[ix]) begin
        gnt     = '0;
        gnt[ix] = 1'b1;
        gidx    = ix;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel = req_msg[i*2*W +: 2*W];
    end
  end

  assign gcd_in_A   = sel[2*W-1:W];
  assign gcd_in_B   = sel[W-1:0];
  assign can_issue  = gcd_in_rdy && !full;
  // reset_n gating keeps handshakes quiet while reset is held.
  assign req_rdy    = reset_n ? (gnt & {NREQ{can_issue}}) : '0;
  assign gcd_in_val = reset_n && (|req_val) && !full;
  assign fire       = gcd_in_val && gcd_in_rdy;

  always_comb begin
    resp_val = '0;
    if (gcd_out_val && !empty) resp_val[hd] = 1'b1;
  end

  assign resp_msg    = gcd_out;
  assign gcd_out_rdy = !empty && resp_rdy[hd];
  assign ret_fire    = gcd_out_val && gcd_out_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    end
  end

  gcd_arbiter_tagq #(
    .DEPTH (DEPTH),
    .IDW   (IW)
  ) u_tagq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fire),
    .pop     (ret_fire),
    .din     (gidx),
    .head    (hd),
    .full    (full),
    .empty   (empty)
  );

`ifdef GCD_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (fire && gnt[i] && perf_cnt[i*16 +: 16] != 16'hFFFF)
          perf_cnt[i*16 +: 16] <= perf_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural in-order GCD unit.
// Covers GCD_ARBITER_PERF_EN counters when that macro is defined.
module tb_gcd_arbiter;
  import gcd_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int W     = 16;
  localparam int DEPTH = 2;

  typedef struct {
    int         id;
    logic [W-1:0] v;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NREQ*2*W-1:0] req_msg;
  logic [NREQ-1:0]     req_val;
  logic [NREQ-1:0]     req_rdy;
  logic [W-1:0]        resp_msg;
  logic [NREQ-1:0]     resp_val;
  logic [NREQ-1:0]     resp_rdy;
  logic [W-1:0]        gcd_in_A;
  logic [W-1:0]        gcd_in_B;
  logic                gcd_in_val;
  logic                gcd_in_rdy;
  logic [W-1:0]        gcd_out = '0;
  logic                gcd_out_val = 1'b0;
  logic                gcd_out_rdy;
`ifdef GCD_ARBITER_PERF_EN
  logic [NREQ*16-1:0]  perf_cnt;
`endif

  exp_t          sb[$];
  int            order[$];
  logic [W-1:0]  gq[$];
  logic [W-1:0]  xres [NREQ];
  logic [NREQ-1:0] fired;
  int            nvec = 0;
  int            nerr = 0;

  always #5 clk = ~clk;

  gcd_arbiter #(
    .NREQ  (NREQ),
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef GCD_ARBITER_PERF_EN
    .perf_cnt    (perf_cnt),
`endif
    .req_msg     (req_msg),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .resp_msg    (resp_msg),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .gcd_in_A    (gcd_in_A),
    .gcd_in_B    (gcd_in_B),
    .gcd_in_val  (gcd_in_val),
    .gcd_in_rdy  (gcd_in_rdy),
    .gcd_out     (gcd_out),
    .gcd_out_val (gcd_out_val),
    .gcd_out_rdy (gcd_out_rdy)
  );

  function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // External GCD unit: one-cycle latency, results in issue order.
  always @(posedge clk) begin
    if (!reset_n) begin
      gq.delete();
    end else begin
      if (gcd_out_val && gcd_out_rdy) void'(gq.pop_front());
      if (gcd_in_val && gcd_in_rdy) gq.push_back(gcd_fn(gcd_in_A, gcd_in_B));
    end
    gcd_out_val <= (gq.size() != 0);
    gcd_out     <= (gq.size() != 0) ? gq[0] : '0;
  end

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [NREQ-1:0] one;
    if (reset_n && ((resp_val & resp_rdy) != '0)) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL resp_unexpected: resp_val=%b msg=%0d, required none",
                 resp_val, resp_msg);
      end else begin
        e = sb.pop_front();
        one = '0;
        one[e.id] = 1'b1;
        if (resp_val !== one || resp_msg !== e.v) begin
          nerr++;
          $display("FAIL resp: resp_val=%b msg=%0d, required %b msg=%0d",
                   resp_val, resp_msg, one, e.v);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] r);
    opnd_t p;
    p.a = a;
    p.b = b;
    req_msg[i*2*W +: 2*W] = p;
    req_val[i] = 1'b1;
    xres[i] = r;
  endtask

  task automatic at_neg();
    @(negedge clk);
    fired = req_val & req_rdy;
    for (int i = 0; i < NREQ; i++) begin
      if (fired[i]) begin
        sb.push_back('{i, xres[i]});
        order.push_back(i);
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
    req_val = req_val & ~fired;
    fired = '0;
  endtask

  task automatic cyc();
    at_neg();
    to_pos();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((req_val != '0 || sb.size() != 0) && n < 200) begin
      cyc();
      n++;
    end
    nvec++;
    if (n >= 200) begin
      nerr++;
      $display("FAIL %s_timeout: pending=%0d, required 0", nm, sb.size());
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_val = '0;
    sb.delete();
    order.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    req_msg    = '0;
    req_val    = '1;
    resp_rdy   = '1;
    gcd_in_rdy = 1'b1;
    fired      = '0;
    for (int i = 0; i < NREQ; i++) xres[i] = '0;

    @(negedge clk);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_gcd_in_val", gcd_in_val, 0);
    chk("rst_gcd_out_rdy", gcd_out_rdy, 0);
    req_val = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single requester, then probe the pointer through the operand mux.
    set_req(0, 16'd27, 16'd15, 16'd3);
    drain("single");
    chk("single_count", order.size(), 1);
    gcd_in_rdy = 1'b0;
    set_req(0, 16'd1, 16'd1, 16'd1);
    set_req(1, 16'd9, 16'd9, 16'd9);
    at_neg();
    chk("ptr_after_single", gcd_in_A, 9);
    chk("no_rdy_when_gcd_busy", req_rdy, 0);
    to_pos();
    req_val = '0;
    gcd_in_rdy = 1'b1;

    // All four requesters at once.
    do_reset();
    set_req(0, 16'd21, 16'd49, 16'd7);
    set_req(1, 16'd25, 16'd30, 16'd5);
    set_req(2, 16'd19, 16'd27, 16'd1);
    set_req(3, 16'd40, 16'd40, 16'd40);
    drain("all4");
    chk("all4_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      chk($sformatf("grant_order_%0d", k), order[k], k);

    // Back-pressure on requester 2.
    resp_rdy = 4'b1011;
    set_req(2, 16'd250, 16'd190, 16'd10);
    cyc();
    set_req(1, 16'd5, 16'd250, 16'd5);
    cyc();
    set_req(0, 16'd12, 16'd18, 16'd6);
    at_neg();
    chk("bp_gcd_out_rdy", gcd_out_rdy, 0);
    chk("bp_full_req_rdy", req_rdy, 0);
    chk("bp_resp_val_hd", resp_val, 4'b0100);
    to_pos();
    repeat (18) cyc();
    chk("bp_held_pending", sb.size(), 2);
    chk("bp_req0_waiting", req_val, 4'b0001);
    resp_rdy = '1;
    drain("bp");

    // Full boundary with a coinciding pop.
    do_reset();
    resp_rdy = '0;
    set_req(0, 16'd12, 16'd18, 16'd6);
    set_req(1, 16'd35, 16'd14, 16'd7);
    set_req(2, 16'd17, 16'd51, 16'd17);
    at_neg();
    chk("full_fire1", req_rdy, 4'b0001);
    to_pos();
    at_neg();
    chk("full_fire2", req_rdy, 4'b0010);
    to_pos();
    resp_rdy = '1;
    at_neg();
    chk("full_blocked", req_rdy, 0);
    chk("full_in_val", gcd_in_val, 0);
    chk("full_pop_same_cycle", gcd_out_rdy, 1);
    to_pos();
    at_neg();
    chk("full_resume", req_rdy, 4'b0100);
    to_pos();
    drain("full");

    // Reset with one tag in flight.
    resp_rdy = '0;
    set_req(0, 16'd8, 16'd12, 16'd4);
    cyc();
    set_req(1, 16'd3, 16'd6, 16'd3);
    #2;
    resp_rdy = '1;
    reset_n = 1'b0;
    #1;
    chk("async_req_rdy", req_rdy, 0);
    chk("async_in_val", gcd_in_val, 0);
    chk("async_resp_val", resp_val, 0);
    chk("async_out_rdy", gcd_out_rdy, 0);
    req_val = '0;
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    order.delete();
    gcd_in_rdy = 1'b0;
    set_req(0, 16'd7, 16'd7, 16'd7);
    set_req(3, 16'd0, 16'd0, 16'd0);
    at_neg();
    chk("post_rst_ptr", gcd_in_A, 7);
    chk("post_rst_empty", resp_val, 0);
    to_pos();
    req_val[0] = 1'b0;
    gcd_in_rdy = 1'b1;
    drain("zero");
    chk("zero_count", order.size(), 1);

`ifdef GCD_ARBITER_PERF_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_req(1, 16'd6, 16'd4, 16'd2);
      drain("perf1");
    end
    for (int k = 0; k < 2; k++) begin
      set_req(0, 16'd9, 16'd6, 16'd3);
      drain("perf0");
    end
    chk("perf_cnt0", perf_cnt[15:0], 2);
    chk("perf_cnt1", perf_cnt[31:16], 5);
    chk("perf_cnt23", perf_cnt[63:32], 0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
